// File: rtl/link_rx_fifo_pkg.sv
// Shared encodings for the link handshake FSMs and default link parameters.
// Imported by the receive FIFO top and its storage core.
package link_rx_fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;

  // Receive-side handshake FSM used inside link_rx_fifo.
  typedef enum logic {
    LINK_IDLE  = 1'b0,
    LINK_ACKED = 1'b1
  } link_state_e;

  // Encodings shared with the upstream master_fsm and the generic slave_fsm.
  typedef enum logic [1:0] {
    MST_IDLE     = 2'd0,
    MST_REQ      = 2'd1,
    MST_WAIT_ACK = 2'd2
  } master_state_e;

  typedef enum logic [1:0] {
    SLV_IDLE  = 2'd0,
    SLV_ACKED = 2'd1,
    SLV_HOLD  = 2'd2
  } slave_state_e;

endpackage

// File: rtl/link_fifo_core.sv
// Circular FIFO storage with wrap-around pointers and an occupancy counter.
// Storage is unreset; only pointers and count are cleared by rst.
module link_fifo_core
  import link_rx_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  always_comb begin
    full    = (count_q == (AW+1)'(DEPTH));
    empty   = (count_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/link_rx_fifo.sv
// Link receiver: 4-phase req/ack slave feeding a FIFO, with a burst counter
// that raises a sticky done once BURST_LEN words have arrived and drained.
module link_rx_fifo
  import link_rx_fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic [DATA_W-1:0]      data,
  output logic                   ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   done
);

  localparam int              WW        = $clog2(BURST_LEN + 1);
  localparam logic [WW-1:0]   BURST_MAX = WW'(BURST_LEN);

  link_state_e   state_q, state_d;
  logic [WW-1:0] words_q, words_d;
  logic          done_q, done_d;
  logic          push, pop, full, empty;

  // Handshake FSM: one write per req pulse, held off while full or done.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      LINK_IDLE: begin
        if (req && !full && !done_q) begin
          push    = 1'b1;
          state_d = LINK_ACKED;
        end
      end
      LINK_ACKED: begin
        if (!req) state_d = LINK_IDLE;
      end
      default: state_d = LINK_IDLE;
    endcase
  end

  always_comb begin
    words_d = words_q;
    if (push && (words_q != BURST_MAX)) words_d = words_q + WW'(1);
    done_d = done_q || ((words_q == BURST_MAX) && empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LINK_IDLE;
      words_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      done_q  <= done_d;
    end
  end

  assign pop       = !empty && out_ready;
  assign out_valid = !empty;
  assign ack       = (state_q == LINK_ACKED);
  assign done      = done_q;

  link_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (data),
    .pop     (pop),
    .rd_data (out_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_link_rx_fifo.sv
// Bench for link_rx_fifo: two instances (BURST_LEN 4 and 16) share stimulus
// and are each compared every cycle against a queue-style occupancy model.
module tb_link_rx_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic [7:0] data = 8'h00;
  logic       out_ready = 1'b0;

  logic       ack_o  [2];
  logic       ov_o   [2];
  logic [7:0] od_o   [2];
  logic [2:0] cnt_o  [2];
  logic       done_o [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model: pushed words kept in order; occupancy is pushes minus pops.
  logic [7:0] hist [2][1024];
  int         npush [2];
  int         npop  [2];
  int         words [2];
  bit         acked [2];
  bit         mdone [2];

  int         sel = 0;
  bit         log_en = 1'b0;
  logic [7:0] wlog [$];
  int         maxc = 0;

  always #5 clk = ~clk;

  link_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .BURST_LEN(4)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack_o[0]),
    .out_valid(ov_o[0]), .out_ready(out_ready), .out_data(od_o[0]),
    .count(cnt_o[0]), .done(done_o[0])
  );

  link_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .BURST_LEN(16)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack_o[1]),
    .out_valid(ov_o[1]), .out_ready(out_ready), .out_data(od_o[1]),
    .count(cnt_o[1]), .done(done_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int burst_of(input int i);
    return (i == 0) ? 4 : 16;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int  occ;
      bit  do_pop, do_push, nd;
      occ = npush[i] - npop[i];
      if (rst) begin
        npush[i] = 0; npop[i] = 0; words[i] = 0; acked[i] = 0; mdone[i] = 0;
      end else begin
        do_pop  = (occ > 0) && out_ready;
        do_push = !acked[i] && req && (occ < DEPTH) && !mdone[i];
        nd      = mdone[i] || ((words[i] == burst_of(i)) && (occ == 0));
        if (do_pop) npop[i]++;
        if (do_push) begin
          hist[i][npush[i] % 1024] = data;
          npush[i]++;
          if (words[i] < burst_of(i)) words[i]++;
        end
        acked[i] = acked[i] ? req : do_push;
        mdone[i] = nd;
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      int occ;
      occ = npush[i] - npop[i];
      chk($sformatf("ack%0d", i), 32'(ack_o[i]), 32'(acked[i]));
      chk($sformatf("valid%0d", i), 32'(ov_o[i]), 32'(occ > 0));
      chk($sformatf("count%0d", i), 32'(cnt_o[i]), 32'(occ));
      chk($sformatf("done%0d", i), 32'(done_o[i]), 32'(mdone[i]));
      if (occ > 0)
        chk($sformatf("data%0d", i), 32'(od_o[i]), 32'(hist[i][npop[i] % 1024]));
    end
  endtask

  task automatic cycle();
    if (log_en && ov_o[1] && out_ready) wlog.push_back(od_o[1]);
    model_step();
    @(posedge clk);
    #1;
    if (32'(cnt_o[1]) > maxc) maxc = 32'(cnt_o[1]);
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic handshake(input logic [7:0] d);
    int n;
    req  = 1'b1;
    data = d;
    n    = 0;
    do begin
      cycle();
      n++;
    end while (!ack_o[sel] && n < 20);
    chk("hs_ack_rise", 32'(ack_o[sel]), 32'd1);
    req = 1'b0;
    cycle();
    chk("hs_ack_fall", 32'(ack_o[sel]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_bp [4];
    int         n;
    exp_bp[0] = 8'h22; exp_bp[1] = 8'h33; exp_bp[2] = 8'h44; exp_bp[3] = 8'h55;
    for (int i = 0; i < 2; i++) begin
      npush[i] = 0; npop[i] = 0; words[i] = 0; acked[i] = 0; mdone[i] = 0;
    end

    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_ack", 32'(ack_o[0]), 32'd0);
    chk("rst_valid", 32'(ov_o[0]), 32'd0);
    chk("rst_count", 32'(cnt_o[0]), 32'd0);
    chk("rst_done", 32'(done_o[0]), 32'd0);

    // Single word
    sel = 0;
    out_ready = 1'b0;
    req = 1'b1; data = 8'hA5;
    cycle();
    chk("single_ack", 32'(ack_o[0]), 32'd1);
    chk("single_valid", 32'(ov_o[0]), 32'd1);
    chk("single_data", 32'(od_o[0]), 32'hA5);
    chk("single_count", 32'(cnt_o[0]), 32'd1);
    req = 1'b0;
    cycle();
    chk("single_ack_low", 32'(ack_o[0]), 32'd0);

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    handshake(8'h11); handshake(8'h22); handshake(8'h33); handshake(8'h44);
    chk("bp_full", 32'(cnt_o[0]), 32'd4);
    req = 1'b1; data = 8'h55;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_ack_held", 32'(ack_o[0]), 32'd0);
    end
    chk("bp_head", 32'(od_o[0]), 32'h11);
    out_ready = 1'b1;
    cycle();
    chk("bp_no_ack_on_pop", 32'(ack_o[0]), 32'd0);
    chk("bp_count3", 32'(cnt_o[0]), 32'd3);
    out_ready = 1'b0;
    cycle();
    chk("bp_ack_55", 32'(ack_o[0]), 32'd1);
    chk("bp_count4", 32'(cnt_o[0]), 32'd4);
    req = 1'b0;
    cycle();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain", 32'(od_o[0]), 32'(exp_bp[k]));
      cycle();
    end
    chk("bp_empty", 32'(ov_o[0]), 32'd0);

    // Wrap with simultaneous push/pop on the BURST_LEN=16 instance
    do_reset();
    sel = 1;
    out_ready = 1'b1;
    maxc = 0;
    wlog.delete();
    log_en = 1'b1;
    for (int k = 0; k < 10; k++) handshake(8'(k));
    cycle();
    log_en = 1'b0;
    chk("wrap_maxcount", 32'(maxc), 32'd1);
    chk("wrap_npops", 32'(wlog.size()), 32'd10);
    for (int k = 0; k < wlog.size() && k < 10; k++)
      chk("wrap_order", 32'(wlog[k]), 32'(k));

    // Done
    do_reset();
    sel = 0;
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) handshake(8'(k));
    out_ready = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (cnt_o[0] != 3'd0 && n < 20);
    chk("done_drained", 32'(cnt_o[0]), 32'd0);
    chk("done_not_yet", 32'(done_o[0]), 32'd0);
    cycle();
    chk("done_set", 32'(done_o[0]), 32'd1);
    req = 1'b1; data = 8'h66;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("done_ignores_req", 32'(ack_o[0]), 32'd0);
    end
    req = 1'b0;
    cycle();
    chk("done_sticky", 32'(done_o[0]), 32'd1);

    // Reset mid-operation
    do_reset();
    out_ready = 1'b0;
    handshake(8'hAA);
    handshake(8'hBB);
    req = 1'b1; data = 8'hCC;
    cycle();
    chk("mid_ack", 32'(ack_o[0]), 32'd1);
    rst = 1'b1;
    req = 1'b0;
    cycle();
    rst = 1'b0;
    chk("mid_rst_ack", 32'(ack_o[0]), 32'd0);
    chk("mid_rst_valid", 32'(ov_o[0]), 32'd0);
    chk("mid_rst_count", 32'(cnt_o[0]), 32'd0);
    chk("mid_rst_done", 32'(done_o[0]), 32'd0);
    handshake(8'h7E);
    chk("mid_new_data", 32'(od_o[0]), 32'h7E);
    chk("mid_new_count", 32'(cnt_o[0]), 32'd1);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) sel = 1;
      rst = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!req && !ack_o[sel]) begin
        if ($urandom_range(0, 1) == 1) begin
          req  = 1'b1;
          data = 8'($urandom);
        end
      end else if (req && ack_o[sel]) begin
        if ($urandom_range(0, 3) != 0) req = 1'b0;
      end
      cycle();
    end
    rst = 1'b0;
    req = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/link_rx_fifo.md
LINK_RX_FIFO -- requirements
Module: link_rx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning width of the link data word and of out_data.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries; DEPTH is a power of two and at least 2.
REQ-003 The block SHALL have parameter BURST_LEN, default 4, meaning the number of words per transaction before done asserts; BURST_LEN is at least 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port req, input, 1 bit: link request from the upstream master_fsm.
REQ-007 The block SHALL have port data, input, DATA_W bits: link word, stable while req is high.
REQ-008 The block SHALL have port ack, output, 1 bit: registered link acknowledge to the master.
REQ-009 The block SHALL have port out_valid, output, 1 bit: FIFO head holds a word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream consumer accepts the head word.
REQ-011 The block SHALL have port out_data, output, DATA_W bits: FIFO head word, valid only when out_valid is high.
REQ-012 The block SHALL have port count, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-013 The block SHALL have port done, output, 1 bit: sticky flag that the burst was received and drained.

Function
REQ-014 The link side SHALL implement a 4-phase req/ack slave with states IDLE (ack=0) and ACKED (ack=1).
REQ-015 In IDLE, req=1 with the FIFO not full SHALL write data into the FIFO at that edge, set ack=1 and go to ACKED.
REQ-016 In IDLE, req=1 with the FIFO full SHALL keep ack=0, perform no write, and hold IDLE; this is backpressure, no word is lost.
REQ-017 In ACKED, req=0 SHALL clear ack and return to IDLE; req=1 SHALL hold ACKED with no further write, so each req pulse writes exactly one word.
REQ-018 Once done=1, IDLE SHALL ignore req, with ack held at 0, until reset.
REQ-019 A pop SHALL occur on every edge where out_valid=1 and out_ready=1; out_data SHALL then present the next entry, or out_valid SHALL drop if the FIFO is empty.
REQ-020 Latency SHALL be one cycle: a word written at edge k gives out_valid=1 and that word on out_data after edge k.
REQ-021 A push and a pop on the same edge SHALL leave count unchanged and SHALL be legal at any occupancy; full is evaluated before the edge.
REQ-022 count SHALL equal pushes minus pops; full is count==DEPTH and empty is count==0.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH with no gap or duplicate at the wrap.
REQ-024 A words-received counter SHALL increment on each push and saturate at BURST_LEN.
REQ-025 done SHALL set on the edge after words-received reaches BURST_LEN and the FIFO becomes empty, and SHALL stay 1 until rst.
REQ-026 out_valid SHALL never be 1 when count==0.
REQ-027 ack SHALL never rise while the FIFO is full.

Reset
REQ-028 rst=1 at an edge SHALL force ack=0, out_valid=0, count=0, done=0, state IDLE, both pointers 0 and words-received 0.
REQ-029 Reset mid-handshake or with a non-empty FIFO SHALL discard all stored words.
REQ-030 After reset, a req still high SHALL be treated as a new request on the first edge with rst=0.
REQ-031 FIFO storage contents need no reset.

Structure
REQ-032 A shared package SHALL hold the link FSM state encoding (IDLE, ACKED) and the default DATA_W, alongside the master_fsm/slave_fsm encodings.
REQ-033 FIFO storage, pointers and count SHALL be one sub-module named link_fifo_core; the handshake FSM and burst/done logic stay in link_rx_fifo.

Verification
REQ-034 Single word: reset, then req=1 with data=8'hA5 and out_ready=0 -> ack=1 next cycle, out_valid=1, out_data=A5, count=1; req=0 -> ack=0 next cycle.
REQ-035 Backpressure: out_ready=0, push 4 words 11,22,33,44, then a 5th req with data 55 -> ack stays 0; raise out_ready for one cycle -> 11 pops, then 55 is acked and written; drain order is 22,33,44,55.
REQ-036 Wrap and simultaneous push/pop: out_ready=1 throughout, 10 consecutive handshakes with data 00..09 -> outputs 00..09 in order, count never exceeds 1, pointers wrap twice.
REQ-037 Done: BURST_LEN=4, push 01..04 and drain -> done=1 one cycle after count reaches 0; a further req -> ack stays 0.
REQ-038 Reset mid-operation: two words stored and ack=1, assert rst for one cycle -> ack=0, out_valid=0, count=0, done=0; the next handshake with 7E -> out_data=7E.
